// File: rtl/stats_pkg.sv
// Shared Q16.16 constants, FSM encoding and a saturating right-shift helper for the
// statistics pipeline (variance_acc and the downstream sqrt/mean-std stages).
package stats_pkg;

  localparam int          FRAC_BITS = 16;
  localparam logic [31:0] Q_ONE     = 32'h0001_0000;

  typedef logic [2:0] state_t;

  localparam state_t ST_ACC  = 3'd0;
  localparam state_t ST_MEAN = 3'd1;
  localparam state_t ST_SQ   = 3'd2;
  localparam state_t ST_VAR  = 3'd3;
  localparam state_t ST_OUT  = 3'd4;

  // Shift val right by sh and clamp to out_w ones; callers size-cast the result down.
  function automatic logic [127:0] sat_shr(input logic [127:0] val, input int sh,
                                           input int out_w);
    logic [127:0] shifted;
    logic [127:0] limit;
    shifted = val >> sh;
    limit   = (128'd1 << out_w) - 128'd1;
    return (shifted > limit) ? limit : shifted;
  endfunction

endpackage

// File: rtl/sq_mult.sv
// Combinational squarer: signed W-bit operand to its unsigned 2W-bit square.
module sq_mult #(
  parameter int W = 32
) (
  input  logic [W-1:0]   a,
  output logic [2*W-1:0] sq
);

  logic signed [2*W-1:0] prod;

  // A signed square is never negative, so the 2W-bit product reads as unsigned.
  assign prod = $signed(a) * $signed(a);
  assign sq   = $unsigned(prod);

endmodule

// File: rtl/variance_acc.sv
// Frame mean/variance accumulator feeding the sqrt radicand port; result valid 3 cycles
// after the last sample, input held off (s_axis_tready=0) until the result is taken.
module variance_acc
  import stats_pkg::*;
#(
  parameter int WIDTH = 31,
  parameter int LOG2N = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [WIDTH:0] s_axis_tdata,
  input  logic           s_axis_tvalid,
  output logic           s_axis_tready,
  input  logic           s_axis_tlast,
  output logic [WIDTH:0] m_axis_tdata,
  output logic           m_axis_tvalid,
  input  logic           m_axis_tready,
  output logic [WIDTH:0] mean_out,
  output logic           frame_err
);

  localparam int W   = WIDTH + 1;
  localparam int SW  = W + LOG2N;
  localparam int QW  = 2 * W;
  localparam int SQW = 2 * W + LOG2N;
  localparam logic [LOG2N-1:0] LAST_CNT = '1;

  state_t state_q, state_d;

  logic [LOG2N-1:0]     count_q, count_d;
  logic signed [SW-1:0] sum_q, sum_d;
  logic [SQW-1:0]       sumsq_q, sumsq_d;
  logic                 err_q, err_d;
  logic [W-1:0]         mean_q, mean_d;
  logic [QW-1:0]        msq_q, msq_d;
  logic [QW-1:0]        mean2_q, mean2_d;
  logic [W-1:0]         tdata_q, tdata_d;
  logic [W-1:0]         mean_out_q, mean_out_d;
  logic                 frame_err_q, frame_err_d;
  logic                 m_vld_q, m_vld_d;

  logic [QW-1:0] x_sq;
  logic [QW-1:0] mean_sq;
  logic [QW:0]   diff;
  logic          s_hs;
  logic          m_hs;

  sq_mult #(.W(W)) u_sq_acc  (.a(s_axis_tdata), .sq(x_sq));
  sq_mult #(.W(W)) u_sq_mean (.a(mean_q),       .sq(mean_sq));

  assign s_hs = s_axis_tvalid & s_axis_tready;
  assign m_hs = m_axis_tvalid & m_axis_tready;

  // One extra bit so a truncation-induced negative variance is visible as a sign.
  assign diff = {1'b0, msq_q} - {1'b0, mean2_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_ACC:  if (s_hs && count_q == LAST_CNT) state_d = ST_MEAN;
      ST_MEAN: state_d = ST_SQ;
      ST_SQ:   state_d = ST_VAR;
      ST_VAR:  state_d = ST_OUT;
      ST_OUT:  if (m_hs) state_d = ST_ACC;
      default: state_d = ST_ACC;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    sum_d       = sum_q;
    sumsq_d     = sumsq_q;
    err_d       = err_q;
    mean_d      = mean_q;
    msq_d       = msq_q;
    mean2_d     = mean2_q;
    tdata_d     = tdata_q;
    mean_out_d  = mean_out_q;
    frame_err_d = frame_err_q;
    m_vld_d     = m_vld_q;
    unique case (state_q)
      ST_ACC: begin
        if (s_hs) begin
          sum_d   = sum_q + {{LOG2N{s_axis_tdata[WIDTH]}}, s_axis_tdata};
          sumsq_d = sumsq_q + {{LOG2N{1'b0}}, x_sq};
          count_d = count_q + LOG2N'(1);
          if (s_axis_tlast != (count_q == LAST_CNT)) err_d = 1'b1;
        end
      end
      ST_MEAN: begin
        // Dropping the low LOG2N bits is the floor division by N.
        mean_d = sum_q[SW-1:LOG2N];
        msq_d  = sumsq_q[SQW-1:LOG2N];
      end
      ST_SQ: begin
        mean2_d = mean_sq;
      end
      ST_VAR: begin
        tdata_d     = diff[QW] ? '0 : W'(sat_shr(128'(diff[QW-1:0]), FRAC_BITS, W));
        mean_out_d  = mean_q;
        frame_err_d = err_q;
        m_vld_d     = 1'b1;
      end
      ST_OUT: begin
        if (m_hs) begin
          m_vld_d = 1'b0;
          sum_d   = '0;
          sumsq_d = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q     <= '0;
      sum_q       <= '0;
      sumsq_q     <= '0;
      err_q       <= 1'b0;
      mean_q      <= '0;
      msq_q       <= '0;
      mean2_q     <= '0;
      tdata_q     <= '0;
      mean_out_q  <= '0;
      frame_err_q <= 1'b0;
      m_vld_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      sum_q       <= sum_d;
      sumsq_q     <= sumsq_d;
      err_q       <= err_d;
      mean_q      <= mean_d;
      msq_q       <= msq_d;
      mean2_q     <= mean2_d;
      tdata_q     <= tdata_d;
      mean_out_q  <= mean_out_d;
      frame_err_q <= frame_err_d;
      m_vld_q     <= m_vld_d;
    end
  end

  always_comb begin
    s_axis_tready = (state_q == ST_ACC);
    m_axis_tvalid = m_vld_q;
    m_axis_tdata  = tdata_q;
    mean_out      = mean_out_q;
    frame_err     = frame_err_q;
  end

endmodule

// File: tb/tb_variance_acc.sv
// Directed bench for variance_acc: expected results queued per frame and checked on output.
module tb_variance_acc;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] mean_out;
  logic        frame_err;

  typedef struct packed {
    logic [31:0] tdata;
    logic [31:0] mean;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] fr[16];
  int          total = 0;
  int          bad   = 0;

  variance_acc #(.WIDTH(31), .LOG2N(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .mean_out      (mean_out),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [31:0] td, input logic [31:0] mn, input logic er);
    exp_t e;
    e.tdata = td;
    e.mean  = mn;
    e.err   = er;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [31:0] smp[16], input int last_pos, input bit gaps,
                            input int nsamp);
    for (int i = 0; i < nsamp; i++) begin
      int g;
      int w;
      bit acc;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      s_axis_tdata  = smp[i];
      s_axis_tlast  = (i == last_pos);
      s_axis_tvalid = 1'b1;
      w   = 0;
      acc = 1'b0;
      while (!acc && w < 100) begin
        acc = s_axis_tready;
        @(posedge clk); #1;
        w++;
      end
      if (!acc) chk("accept_timeout", 64'(acc), 64'd1);
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 0;
    while (!m_axis_tvalid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_vld"}, 64'(m_axis_tvalid), 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_tdata"}, 64'(m_axis_tdata), 64'(e.tdata));
      chk({tag, "_mean"},  64'(mean_out),     64'(e.mean));
      chk({tag, "_err"},   64'(frame_err),    64'(e.err));
    end
  endtask

  task automatic take_result(input string tag);
    @(posedge clk); #1;
    chk({tag, "_vld_drop"}, 64'(m_axis_tvalid), 64'd0);
    chk({tag, "_s_rdy"},    64'(s_axis_tready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_rdy", 64'(s_axis_tready), 64'd1);
    chk("rst_m_vld", 64'(m_axis_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_axis_tdata),  64'd0);
    chk("rst_mean",  64'(mean_out),      64'd0);
    chk("rst_err",   64'(frame_err),     64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Constant 2.0: zero variance.
    for (int i = 0; i < 16; i++) fr[i] = 32'h0002_0000;
    push_exp(32'h0000_0000, 32'h0002_0000, 1'b0);
    send_frame(fr, 15, 1'b0, 16);
    wait_result("const2", 3);
    take_result("const2");

    // +1.0 / -1.0 alternating.
    for (int i = 0; i < 16; i++) fr[i] = (i % 2 == 0) ? 32'h0001_0000 : 32'hFFFF_0000;
    push_exp(32'h0001_0000, 32'h0000_0000, 1'b0);
    send_frame(fr, 15, 1'b0, 16);
    wait_result("pm1", 3);
    take_result("pm1");

    // Ramp 0..15 with random input gaps.
    for (int i = 0; i < 16; i++) fr[i] = 32'(i) << 16;
    push_exp(32'h0015_4000, 32'h0007_8000, 1'b0);
    send_frame(fr, 15, 1'b1, 16);
    wait_result("ramp_gap", 3);
    take_result("ramp_gap");

    // Extremes saturate the radicand; also hold off the result for 10 cycles.
    for (int i = 0; i < 16; i++) fr[i] = (i % 2 == 0) ? 32'h7FFF_0000 : 32'h8000_0000;
    push_exp(32'hFFFF_FFFF, 32'hFFFF_8000, 1'b0);
    m_axis_tready = 1'b0;
    send_frame(fr, 15, 1'b0, 16);
    wait_result("sat", 3);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("hold_vld",   64'(m_axis_tvalid), 64'd1);
      chk("hold_tdata", 64'(m_axis_tdata),  64'hFFFF_FFFF);
      chk("hold_mean",  64'(mean_out),      64'hFFFF_8000);
      chk("hold_s_rdy", 64'(s_axis_tready), 64'd0);
    end
    m_axis_tready = 1'b1;
    take_result("sat");

    // Early tlast: frame still closes on the 16th sample, flagged.
    for (int i = 0; i < 16; i++) fr[i] = 32'h0002_0000;
    push_exp(32'h0000_0000, 32'h0002_0000, 1'b1);
    send_frame(fr, 4, 1'b0, 16);
    wait_result("early_last", 3);
    take_result("early_last");

    // Clean frame afterwards: error flag must not carry over.
    for (int i = 0; i < 16; i++) fr[i] = 32'(i) << 16;
    push_exp(32'h0015_4000, 32'h0007_8000, 1'b0);
    send_frame(fr, 15, 1'b0, 16);
    wait_result("err_clear", 3);
    take_result("err_clear");

    // Reset mid-frame after 8 samples, then a fresh constant frame.
    send_frame(fr, 15, 1'b0, 8);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_tdata", 64'(m_axis_tdata),  64'd0);
    chk("midrst_mean",  64'(mean_out),      64'd0);
    chk("midrst_vld",   64'(m_axis_tvalid), 64'd0);
    chk("midrst_s_rdy", 64'(s_axis_tready), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) fr[i] = 32'h0003_4000;
    push_exp(32'h0000_0000, 32'h0003_4000, 1'b0);
    send_frame(fr, 15, 1'b0, 16);
    wait_result("post_rst", 3);
    take_result("post_rst");

    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
